// File: rtl/lcd_pkg.sv
// Shared constants for the HD44780 write-only interface:
// FSM state codes, power-on init command table and slow-command helpers.
package lcd_pkg;

    localparam logic [2:0] S_PWR_WAIT = 3'd0;
    localparam logic [2:0] S_LOAD     = 3'd1;
    localparam logic [2:0] S_SETUP    = 3'd2;
    localparam logic [2:0] S_EN_HI    = 3'd3;
    localparam logic [2:0] S_HOLD     = 3'd4;
    localparam logic [2:0] S_EXEC     = 3'd5;
    localparam logic [2:0] S_IDLE     = 3'd6;

    localparam int INIT_LEN = 4;
    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;

    // 8-bit bus/2-line, display on, clear, entry mode increment
    localparam logic [31:0] INIT_CMD = {8'h38, 8'h0C, CMD_CLEAR, 8'h06};

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        return INIT_CMD[(3 - idx) * 8 +: 8];
    endfunction

    // 0x03 decodes as return-home too, so it needs the long wait
    function automatic logic slow_cmd(input logic rs, input logic [7:0] db);
        return !rs && (db == CMD_CLEAR || db == CMD_HOME || db == 8'h03);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Loadable down-counter; holds at zero until reloaded.
// Reset value lets the power-up wait start counting without a load cycle.
module lcd_delay_timer #(
    parameter int W       = 8,
    parameter int RST_VAL = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= W'(RST_VAL);
        end else if (load) begin
            cnt <= value;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/lcd_hd44780_writer.sv
// HD44780 write-only interface: power-on init, then one byte per
// valid/ready transfer with setup/enable/hold/execute timing.
module lcd_hd44780_writer
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC = 4,
    parameter int EN_CYC    = 12,
    parameter int HOLD_CYC  = 4,
    parameter int EXEC_CYC  = 2000,
    parameter int CLEAR_CYC = 82000,
    parameter int PWRUP_CYC = 750000
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_rs,
    input  logic [7:0] in_data,
    output logic [7:0] lcd_db,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic       init_done
);

    localparam int MAX_CYC = max2(max2(max2(SETUP_CYC, EN_CYC), max2(HOLD_CYC, EXEC_CYC)),
                                  max2(CLEAR_CYC, PWRUP_CYC));
    localparam int W = $clog2(MAX_CYC) + 1;

    if (SETUP_CYC < 1 || EN_CYC < 1 || HOLD_CYC < 1 ||
        EXEC_CYC < 1 || CLEAR_CYC < 1 || PWRUP_CYC < 1) begin : g_bad_param
        $fatal(1, "lcd_hd44780_writer: every *_CYC parameter must be >= 1");
    end

    localparam logic [W-1:0] L_SETUP = W'(SETUP_CYC - 1);
    localparam logic [W-1:0] L_EN    = W'(EN_CYC - 1);
    localparam logic [W-1:0] L_HOLD  = W'(HOLD_CYC - 1);
    localparam logic [W-1:0] L_EXEC  = W'(EXEC_CYC - 1);
    localparam logic [W-1:0] L_CLEAR = W'(CLEAR_CYC - 1);

    logic [2:0]   state_q, state_d;
    logic [1:0]   idx_q;
    logic         done_q;
    logic         pend_rs;
    logic [7:0]   pend_data;
    logic [7:0]   db_q;
    logic         rs_q;
    logic         t_load;
    logic [W-1:0] t_value;
    logic         t_zero;
    logic         accept;
    logic         init_last;
    logic         exec_end;

    lcd_delay_timer #(
        .W       (W),
        .RST_VAL (PWRUP_CYC - 1)
    ) u_timer (
        .clk   (clk_clk),
        .rst_n (reset_reset_n),
        .load  (t_load),
        .value (t_value),
        .zero  (t_zero)
    );

    assign in_ready  = (state_q == S_IDLE) && done_q;
    assign accept    = in_valid && in_ready;
    assign init_last = (idx_q == 2'(INIT_LEN - 1));
    assign exec_end  = (state_q == S_EXEC) && t_zero;

    always_comb begin
        state_d = state_q;
        t_load  = 1'b0;
        t_value = '0;
        unique case (state_q)
            S_PWR_WAIT: if (t_zero) state_d = S_LOAD;
            S_LOAD: begin
                state_d = S_SETUP;
                t_load  = 1'b1;
                t_value = L_SETUP;
            end
            S_SETUP: if (t_zero) begin
                state_d = S_EN_HI;
                t_load  = 1'b1;
                t_value = L_EN;
            end
            S_EN_HI: if (t_zero) begin
                state_d = S_HOLD;
                t_load  = 1'b1;
                t_value = L_HOLD;
            end
            S_HOLD: if (t_zero) begin
                state_d = S_EXEC;
                t_load  = 1'b1;
                t_value = slow_cmd(rs_q, db_q) ? L_CLEAR : L_EXEC;
            end
            S_EXEC: if (t_zero) begin
                state_d = (!done_q && !init_last) ? S_LOAD : S_IDLE;
            end
            S_IDLE: if (accept) state_d = S_LOAD;
            default: state_d = S_PWR_WAIT;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q   <= S_PWR_WAIT;
            idx_q     <= '0;
            done_q    <= 1'b0;
            pend_rs   <= 1'b0;
            pend_data <= '0;
            db_q      <= '0;
            rs_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (exec_end && !done_q) begin
                if (init_last) done_q <= 1'b1;
                else           idx_q  <= idx_q + 2'd1;
            end
            if (accept) begin
                pend_rs   <= in_rs;
                pend_data <= in_data;
            end
            // Bus only moves here, so it is frozen through EN and HOLD
            if (state_q == S_LOAD) begin
                db_q <= done_q ? pend_data : init_cmd(idx_q);
                rs_q <= done_q ? pend_rs : 1'b0;
            end
        end
    end

    assign lcd_db    = db_q;
    assign lcd_rs    = rs_q;
    assign lcd_rw    = 1'b0;
    assign lcd_en    = (state_q == S_EN_HI);
    assign init_done = done_q;

endmodule

// File: tb/tb_lcd_hd44780_writer.sv
// Self-checking bench for lcd_hd44780_writer: init sequence, host writes,
// back-to-back handshake, clear/home waits and reset during an EN pulse.
module tb_lcd_hd44780_writer;

    localparam int SETUP = 2;
    localparam int EN    = 3;
    localparam int HOLD  = 2;
    localparam int EXEC  = 5;
    localparam int CLEAR = 20;
    localparam int PWRUP = 50;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_rs = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic [7:0] lcd_db;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;
    logic       init_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    lcd_hd44780_writer #(
        .SETUP_CYC (SETUP),
        .EN_CYC    (EN),
        .HOLD_CYC  (HOLD),
        .EXEC_CYC  (EXEC),
        .CLEAR_CYC (CLEAR),
        .PWRUP_CYC (PWRUP)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rs         (in_rs),
        .in_data       (in_data),
        .lcd_db        (lcd_db),
        .lcd_rs        (lcd_rs),
        .lcd_rw        (lcd_rw),
        .lcd_en        (lcd_en),
        .init_done     (init_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic fail(input string tag);
        checks++;
        errors++;
        $error("FAIL %s observed=timeout expected=event", tag);
    endtask

    // Reference timing derived from the command semantics
    function automatic int exec_of(input int rs, input int db);
        return (rs == 0 && db >= 1 && db <= 3) ? CLEAR : EXEC;
    endfunction

    function automatic int gap_of(input int rs, input int db);
        return EN + HOLD + exec_of(rs, db) + 1 + SETUP;
    endfunction

    // Pulse monitor: records every completed EN pulse, checks bus stability
    int q_db[$];
    int q_rs[$];
    int q_rise[$];
    int q_w[$];
    logic       prev_en = 1'b0;
    logic [7:0] prev_db = 8'h00;
    logic       prev_rs = 1'b0;
    logic [7:0] cap_db = 8'h00;
    logic       cap_rs = 1'b0;
    int rise_s = 0;
    int chg_s = 0;
    int hold_left = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_en = 1'b0;
            hold_left = 0;
            chg_s = cyc;
            prev_db = lcd_db;
            prev_rs = lcd_rs;
        end else begin
            chk("rw_zero", lcd_rw, 0);
            if (lcd_db !== prev_db || lcd_rs !== prev_rs) chg_s = cyc;
            if (lcd_en && !prev_en) begin
                cap_db = lcd_db;
                cap_rs = lcd_rs;
                rise_s = cyc;
                chk("setup_stable", (cyc - chg_s) >= SETUP, 1);
            end else if (lcd_en) begin
                chk("db_stable_en", {lcd_rs, lcd_db}, {cap_rs, cap_db});
            end
            if (!lcd_en && prev_en) begin
                q_db.push_back(int'(cap_db));
                q_rs.push_back(int'(cap_rs));
                q_rise.push_back(rise_s);
                q_w.push_back(cyc - rise_s);
                hold_left = HOLD;
            end
            if (!lcd_en && hold_left > 0) begin
                chk("db_stable_hold", {lcd_rs, lcd_db}, {cap_rs, cap_db});
                hold_left--;
            end
            prev_en = lcd_en;
            prev_db = lcd_db;
            prev_rs = lcd_rs;
        end
    end

    task automatic wait_pulses(input int n, input int budget);
        for (int i = 0; i < budget && q_db.size() < n; i++) @(negedge clk);
        if (q_db.size() < n) fail("pulse_wait");
    endtask

    task automatic wait_ready(input int budget, output int stamp);
        stamp = -1;
        for (int i = 0; i < budget; i++) begin
            if (in_ready) begin
                stamp = cyc;
                break;
            end
            @(negedge clk);
        end
        if (stamp < 0) fail("ready_wait");
    endtask

    task automatic check_pulse(input string tag, input int k, input int rs,
                               input int db, input int rise);
        if (q_db.size() > k) begin
            chk({tag, "_db"}, q_db[k], db);
            chk({tag, "_rs"}, q_rs[k], rs);
            chk({tag, "_width"}, q_w[k], EN);
            chk({tag, "_rise"}, q_rise[k], rise);
        end else begin
            fail({tag, "_missing"});
        end
    endtask

    task automatic check_init(input int rel);
        int cmds[4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
        int exp_rise;
        int rdy;
        int seen;
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            if (lcd_en) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        if (seen == 0) fail("init_first_en");
        chk("init_done_during_init", init_done, 0);
        chk("ready_during_init", in_ready, 0);
        wait_pulses(4, 400);
        exp_rise = rel + PWRUP + 1 + SETUP;
        for (int i = 0; i < 4; i++) begin
            check_pulse("init", i, 0, cmds[i], exp_rise);
            exp_rise += gap_of(0, cmds[i]);
        end
        wait_ready(100, rdy);
        if (q_rise.size() >= 4)
            chk("init_ready_time", rdy, q_rise[3] + EN + HOLD + EXEC);
        chk("init_done_set", init_done, 1);
        chk("init_pulse_count", q_db.size(), 4);
    endtask

    task automatic send(input logic rs, input logic [7:0] data, input bit keep,
                        output int acc);
        acc = -1;
        in_valid = 1'b1;
        in_rs = rs;
        in_data = data;
        for (int i = 0; i < 200; i++) begin
            if (in_ready) begin
                acc = cyc + 1;
                @(negedge clk);
                if (!keep) in_valid = 1'b0;
                chk("ready_drop", in_ready, 0);
                break;
            end
            @(negedge clk);
        end
        if (acc < 0) begin
            in_valid = 1'b0;
            fail("accept_wait");
        end
    endtask

    task automatic do_write(input string tag, input logic rs, input logic [7:0] data);
        int n;
        int acc;
        int rdy;
        n = q_db.size();
        send(rs, data, 1'b0, acc);
        wait_pulses(n + 1, 100);
        check_pulse(tag, n, int'(rs), int'(data), acc + 1 + SETUP);
        wait_ready(100, rdy);
        chk({tag, "_ready_time"}, rdy,
            acc + 1 + SETUP + EN + HOLD + exec_of(int'(rs), int'(data)));
    endtask

    initial begin
        int rel;
        int acc1;
        int acc2;
        int rdy;
        int n;
        logic       r_rs;
        logic [7:0] r_db;

        repeat (3) @(negedge clk);
        chk("rst_db", lcd_db, 0);
        chk("rst_rs", lcd_rs, 0);
        chk("rst_en", lcd_en, 0);
        chk("rst_rw", lcd_rw, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_done", init_done, 0);
        #2 rst_n = 1'b1;
        rel = cyc;
        @(negedge clk);
        check_init(rel);

        do_write("data_41", 1'b1, 8'h41);

        n = q_db.size();
        send(1'b1, 8'h48, 1'b1, acc1);
        in_data = 8'h49;
        send(1'b1, 8'h49, 1'b0, acc2);
        chk("b2b_accept_time", acc2, acc1 + 1 + SETUP + EN + HOLD + EXEC + 1);
        wait_pulses(n + 2, 100);
        check_pulse("b2b_first", n, 1, 8'h48, acc1 + 1 + SETUP);
        check_pulse("b2b_second", n + 1, 1, 8'h49, acc2 + 1 + SETUP);
        wait_ready(100, rdy);
        chk("b2b_count", q_db.size(), n + 2);

        do_write("home_cmd", 1'b0, 8'h02);
        do_write("home_data", 1'b1, 8'h02);
        do_write("clear_cmd", 1'b0, 8'h01);

        for (int i = 0; i < 8; i++) begin
            r_rs = 1'($urandom_range(0, 1));
            r_db = r_rs ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 7));
            do_write("rand", r_rs, r_db);
        end

        send(1'b1, 8'h55, 1'b0, acc1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (lcd_en) begin
                n = 1;
                break;
            end
            @(negedge clk);
        end
        if (n == 0) fail("mid_write_en");
        #2 rst_n = 1'b0;
        #1;
        chk("async_en", lcd_en, 0);
        chk("async_done", init_done, 0);
        chk("async_ready", in_ready, 0);
        chk("async_db", lcd_db, 0);
        q_db.delete();
        q_rs.delete();
        q_rise.delete();
        q_w.delete();
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        rel = cyc;
        @(negedge clk);
        check_init(rel);
        do_write("post_reset", 1'b1, 8'h5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
